// File: rtl/vga_timing_out_pkg.sv
// Shared timing defaults, colour constants and helpers for the VGA output path.
// The renderers share the colour macros below.
`ifndef VGA_TIMING_OUT_PKG_DEFINES
`define VGA_TIMING_OUT_PKG_DEFINES
`define WHITE 6'b111111
`define RED   6'b110000
`define DITHER50(x, y) ((x[0]) ^ (y[0]))
`endif

package vga_timing_out_pkg;

    // Counter width shared by both axes; totals must fit in it.
    localparam int CNT_W = 10;

    // 640x480@60 timing defaults (pixel clock 25.175 MHz).
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    // One 2-bit channel per DAC colour.
    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    // Split RRGGBB into channels, forcing black while blanking.
    function automatic rgb_t split_color(input logic [5:0] c, input logic visible);
        rgb_t res;
        res = '0;
        if (visible) begin
            res.r = c[5:4];
            res.g = c[3:2];
            res.b = c[1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_timing_out_axis_counter.sv
// One timing axis: a wrapping position counter with active-region and
// sync-window decode. Used once per line (horizontal) and once per frame
// (vertical, stepped by the horizontal wrap).
module vga_axis_counter
    import vga_timing_out_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync_n
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FRONT + SYNC);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic [CNT_W-1:0] count_d, count_q;
    logic             at_last;

    // Next position: advance when stepped, wrapping after the last position.
    always_comb begin
        at_last = (count_q == LAST);
        count_d = count_q;
        if (step) begin
            count_d = at_last ? '0 : count_q + ONE;
        end
    end

    // Position register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count  = count_q;
    assign wrap   = step && at_last;
    assign active = (count_q < ACT_END);
    assign sync_n = !((count_q >= SYNC_START) && (count_q < SYNC_END));

endmodule

// File: rtl/vga_timing_out.sv
// VGA timing generator and output stage: horizontal/vertical/frame counters,
// sync decode, and a single register stage that aligns colour, sync and
// line/frame strobes on the pins one clock after the counters.
module vga_timing_out
    import vga_timing_out_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       color,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             video_active,
    output logic [7:0]       frame,
    output logic [1:0]       r,
    output logic [1:0]       g,
    output logic [1:0]       b,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    logic h_wrap, h_active, h_sync_n;
    logic v_wrap, v_active, v_sync_n;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (1'b1),
        .count  (pix_x),
        .wrap   (h_wrap),
        .active (h_active),
        .sync_n (h_sync_n)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (h_wrap),
        .count  (pix_y),
        .wrap   (v_wrap),
        .active (v_active),
        .sync_n (v_sync_n)
    );

    assign video_active = h_active && v_active;

    logic [7:0] frame_d, frame_q;

    // Frame count advances when the last pixel of the last line wraps.
    always_comb begin
        frame_d = frame_q;
        if (h_wrap && v_wrap) begin
            frame_d = frame_q + 8'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_q <= '0;
        else        frame_q <= frame_d;
    end

    assign frame = frame_q;

    rgb_t rgb_d, rgb_q;
    logic hsync_d, hsync_q;
    logic vsync_d, vsync_q;
    logic line_start_d, line_start_q;
    logic frame_start_d, frame_start_q;

    // Stage-0 values decoded from the current counter position.
    always_comb begin
        rgb_d         = split_color(color, video_active);
        hsync_d       = h_sync_n;
        vsync_d       = v_sync_n;
        line_start_d  = (pix_x == '0);
        frame_start_d = (pix_x == '0) && (pix_y == '0);
    end

    // Output register: everything reaches the pins together, one clock late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign r           = rgb_q.r;
    assign g           = rgb_q.g;
    assign b           = rgb_q.b;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out using a scaled-down raster (16 x 11) so that
// hundreds of frames fit in a short run.
module tb_vga_timing_out;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 16
    localparam int VT = VA + VF + VS + VB;   // 11
    localparam int FT = HT * VT;             // 176 clocks per frame

    logic       clk;
    logic       rst_n;
    logic [5:0] color;
    logic [9:0] pix_x, pix_y;
    logic       video_active;
    logic [7:0] frame;
    logic [1:0] r, g, b;
    logic       hsync, vsync, line_start, frame_start;

    vga_timing_out #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .color        (color),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .video_active (video_active),
        .frame        (frame),
        .r            (r),
        .g            (g),
        .b            (b),
        .hsync        (hsync),
        .vsync        (vsync),
        .line_start   (line_start),
        .frame_start  (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin bundle: {r, g, b, hsync, vsync, line_start, frame_start}
    localparam logic [9:0] RESET_PINS = {6'b000000, 1'b1, 1'b1, 1'b0, 1'b0};

    int         n_checks;
    int         n_fail;
    int         pos;        // clocks since reset release
    int         mode;       // 0: white, 1: counter pattern, 2: random
    logic [9:0] exp_pins;   // expected pins after the next edge
    int         cnt_fs, cnt_ls, cnt_hlow, cnt_vlow;

    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] f;
        logic       act;
        logic [5:0] rgb;
        logic       hs, vs, ls, fs;
    } vec_t;

    vec_t vecs[$];

    // Reference position model from plain arithmetic on elapsed clocks.
    function automatic logic [28:0] model_counters(input int p);
        int x, y, f;
        logic act;
        x   = p % HT;
        y   = (p / HT) % VT;
        f   = (p / FT) % 256;
        act = (x < HA) && (y < VA);
        return {10'(x), 10'(y), 8'(f), act};
    endfunction

    function automatic logic [9:0] model_pins(input int p, input logic [5:0] c);
        int x, y;
        logic act, hs, vs;
        x   = p % HT;
        y   = (p / HT) % VT;
        act = (x < HA) && (y < VA);
        hs  = !((x >= HA + HF) && (x < HA + HF + HS));
        vs  = !((y >= VA + VF) && (y < VA + VF + VS));
        return {(act ? c : 6'b000000), hs, vs, (x == 0), (x == 0 && y == 0)};
    endfunction

    function automatic logic [5:0] pick_color(input int p, input int m);
        logic [9:0] x, y;
        x = 10'(p % HT);
        y = 10'((p / HT) % VT);
        if (m == 0) return 6'b111111;
        if (m == 1) return {x[1:0], y[1:0], 2'b01};
        return 6'($urandom());
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at pos %0d: got %h expected %h", name, pos, act, exp);
        end
    endtask

    // Per-cycle comparison of counters and pins against the model.
    task automatic checkOutput();
        compare("counters", 64'({pix_x, pix_y, frame, video_active}), 64'(model_counters(pos)));
        compare("pins", 64'({r, g, b, hsync, vsync, line_start, frame_start}), 64'(exp_pins));
    endtask

    task automatic driveColor();
        logic [5:0] c;
        c        = pick_color(pos, mode);
        color    = c;
        exp_pins = model_pins(pos, c);
    endtask

    // Advance one clock, check everything, then drive the next colour.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        pos++;
        checkOutput();
        if (pos >= 1 && pos <= FT) begin
            cnt_fs   += int'(frame_start);
            cnt_ls   += int'(line_start);
            cnt_hlow += int'(!hsync);
            cnt_vlow += int'(!vsync);
        end
        driveColor();
    endtask

    // Asynchronous reset mid-stream, checked before any clock edge, then release.
    task automatic resetDut();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compare("reset_async", 64'({pix_x, pix_y, frame, video_active, r, g, b, hsync, vsync, line_start, frame_start}),
                64'({10'd0, 10'd0, 8'd0, 1'b1, RESET_PINS}));
        repeat (2) @(posedge clk);
        #1;
        compare("reset_hold", 64'({pix_x, pix_y, frame, video_active, r, g, b, hsync, vsync, line_start, frame_start}),
                64'({10'd0, 10'd0, 8'd0, 1'b1, RESET_PINS}));
        rst_n    = 1'b1;
        pos      = 0;
        exp_pins = RESET_PINS;
        cnt_fs   = 0;
        cnt_ls   = 0;
        cnt_hlow = 0;
        cnt_vlow = 0;
        checkOutput();
        driveColor();
    endtask

    task automatic addVec(input int n, input int x, input int y, input int f, input logic act,
                          input logic [5:0] rgb, input logic hs, input logic vs,
                          input logic ls, input logic fs);
        vec_t v;
        v.n = n; v.x = 10'(x); v.y = 10'(y); v.f = 8'(f); v.act = act;
        v.rgb = rgb; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pos      = 0;
        mode     = 0;
        rst_n    = 1'b0;
        color    = 6'b000000;
        exp_pins = RESET_PINS;
        cnt_fs = 0; cnt_ls = 0; cnt_hlow = 0; cnt_vlow = 0;

        // Hand-derived checkpoints with white held on the colour input.
        //     n    x  y  f act  rgb    hs vs ls fs
        addVec(0,   0, 0, 0, 1, 6'h00, 1, 1, 0, 0);
        addVec(1,   1, 0, 0, 1, 6'h3f, 1, 1, 1, 1);
        addVec(2,   2, 0, 0, 1, 6'h3f, 1, 1, 0, 0);
        addVec(8,   8, 0, 0, 0, 6'h3f, 1, 1, 0, 0);
        addVec(9,   9, 0, 0, 0, 6'h00, 1, 1, 0, 0);
        addVec(11, 11, 0, 0, 0, 6'h00, 0, 1, 0, 0);
        addVec(13, 13, 0, 0, 0, 6'h00, 0, 1, 0, 0);
        addVec(14, 14, 0, 0, 0, 6'h00, 1, 1, 0, 0);
        addVec(17,  1, 1, 0, 1, 6'h3f, 1, 1, 1, 0);
        addVec(97,  1, 6, 0, 0, 6'h00, 1, 1, 1, 0);
        addVec(113, 1, 7, 0, 0, 6'h00, 1, 0, 1, 0);
        addVec(145, 1, 9, 0, 0, 6'h00, 1, 1, 1, 0);
        addVec(176, 0, 0, 1, 1, 6'h00, 1, 1, 0, 0);
        addVec(177, 1, 0, 1, 1, 6'h3f, 1, 1, 1, 1);

        #12;
        resetDut();
        foreach (vecs[i]) begin
            for (int k = 0; k < 1000 && pos < vecs[i].n; k++) applyStimulus();
            compare($sformatf("vec%0d", i),
                    64'({pix_x, pix_y, frame, video_active, r, g, b, hsync, vsync, line_start, frame_start}),
                    64'({vecs[i].x, vecs[i].y, vecs[i].f, vecs[i].act, vecs[i].rgb,
                         vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs}));
        end

        // Counter-derived colour for latency, plus per-frame strobe/sync totals.
        mode = 1;
        resetDut();
        for (int k = 0; k < 2 * FT; k++) applyStimulus();
        compare("frame_start_count", 64'(cnt_fs), 64'(1));
        compare("line_start_count", 64'(cnt_ls), 64'(VT));
        compare("hsync_low_count", 64'(cnt_hlow), 64'(HS * VT));
        compare("vsync_low_count", 64'(cnt_vlow), 64'(VS * HT));

        // Reset in the middle of a line in frame 2, with hsync low on the pins.
        for (int k = 0; k < 3 * HT + 11; k++) applyStimulus();
        compare("pre_reset_state", 64'({pix_y, pix_x, frame, hsync}), 64'({10'd3, 10'd11, 8'd2, 1'b0}));

        // Random colour over 256+ frames, covering the frame counter wrap.
        mode = 2;
        resetDut();
        for (int k = 0; k < 256 * FT + 2; k++) begin
            applyStimulus();
            if (pos == 256 * FT - 1) compare("frame_255", 64'(frame), 64'(255));
            if (pos == 256 * FT)     compare("frame_wrap", 64'(frame), 64'(0));
            if (pos == 256 * FT + 1) compare("wrap_frame_start", 64'(frame_start), 64'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_out.md
VGA_TIMING_OUT -- requirements
Module: vga_timing_out

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in clocks.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 clk  in  1  pixel clock, 25.175 MHz nominal; the only clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 pix_x  out  10  current horizontal counter, 0..H_TOTAL-1, sent to the flag renderers.
REQ-008 pix_y  out  10  current vertical counter, 0..V_TOTAL-1.
REQ-009 video_active  out  1  high when pix_x < H_ACTIVE and pix_y < V_ACTIVE.
REQ-010 frame  out  8  frame counter for temporal dither and animation.
REQ-011 color  in  6  RRGGBB from the renderer; a combinational function of pix_x/pix_y/frame in the same cycle.
REQ-012 r, g, b  out  2 each  registered colour to the DAC.
REQ-013 hsync, vsync  out  1 each  registered sync, active-low.
REQ-014 line_start, frame_start  out  1 each  single-cycle strobes, registered and aligned with r/g/b.

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525); computed as localparams.
REQ-016 pix_x increments by 1 every clk; at H_TOTAL-1 it wraps to 0 on the next clk.
REQ-017 pix_y increments only on the cycle pix_x wraps; at V_TOTAL-1 with the same wrap it returns to 0.
REQ-018 frame increments by 1 (mod 256) on the cycle both counters wrap together; 255 wraps to 0.
REQ-019 Stage 0 (combinational from the counters): hs_n = 0 iff H_ACTIVE+H_FRONT <= pix_x < H_ACTIVE+H_FRONT+H_SYNC; vs_n = 0 iff V_ACTIVE+V_FRONT <= pix_y < V_ACTIVE+V_FRONT+V_SYNC.
REQ-020 Stage 1 register: r/g/b = color[5:4]/[3:2]/[1:0] when video_active, else 0; hsync/vsync/line_start/frame_start take their stage-0 values; fixed latency of 1 clk from counter to pins.
REQ-021 line_start stage-0 value is (pix_x == 0); frame_start is (pix_x == 0 && pix_y == 0).
REQ-022 The color input is ignored outside the active region; blanking forces 0 regardless of its value.
REQ-023 All comparisons are unsigned 10-bit; parameters require H_TOTAL <= 1024 and V_TOTAL <= 1024.

Reset
REQ-024 While rst_n = 0: pix_x = 0, pix_y = 0, frame = 0, r/g/b = 0, hsync = 1, vsync = 1, line_start = 0, frame_start = 0.
REQ-025 Reset assertion takes effect asynchronously mid-line or mid-frame; release is sampled on clk, and the first clk after release produces stage-1 outputs for (0,0), so frame_start = 1.
REQ-026 video_active is a combinational function of the counters, so it reads 1 during reset.

Structure
REQ-027 The shared package/header holds the 640x480@60 timing defaults, the `WHITE/`RED colour constants and the DITHER50 macro that the renderers already use; this block includes it.
REQ-028 A natural sub-module is vga_axis_counter, one parameterised counter with a wrap output and a sync-window compare, instantiated once for h and once for v.

Verification
REQ-029 Release reset, run 800x525 clks -> exactly 1 frame_start, 525 line_starts, frame 0 -> 1, hsync low for 96 clks per line starting at pix_x = 656 (pins at +1 clk).
REQ-030 Count vsync low over one frame -> 2 lines (1600 clks), starting at pix_y = 490.
REQ-031 color = 6'b111111 held constant -> r/g/b = 3 only during pins-cycles for pix_x 0..639 and pix_y 0..479; 0 at pix_x = 640 and pix_y = 480.
REQ-032 Drive color = {pix_x[1:0], pix_y[1:0], 2'b01} -> the pins equal that value for the previous cycle's counters (1-clk latency check).
REQ-033 Assert rst_n mid-line at pix_x = 300, pix_y = 200 -> all outputs take reset values immediately without waiting for clk; after release, counting restarts at (0,0).
REQ-034 Run 256 frames -> frame wraps 255 -> 0 on the frame_start boundary.
